// File: rtl/spartan_dsp_pkg.sv
// Shared constants for the DSP48A1-style slice: widths, OPMODE bit positions
// and the X/Z operand mux select encodings.
package spartan_dsp_pkg;

    // Datapath widths
    localparam int W_AB = 18;   // A, B, D, BCIN, BCOUT
    localparam int W_M  = 36;   // multiplier product
    localparam int W_P  = 48;   // C, PCIN, P, PCOUT

    // OPMODE bit positions
    localparam int OP_X_LSB    = 0;  // OPMODE[1:0] selects X
    localparam int OP_Z_LSB    = 2;  // OPMODE[3:2] selects Z
    localparam int OP_PRE_EN   = 4;  // pre-adder result feeds B1 when set
    localparam int OP_CARRYIN  = 5;  // carry-in source when CARRYINSEL="OPMODE5"
    localparam int OP_PRE_SUB  = 6;  // pre-adder subtracts (D - B0) when set
    localparam int OP_POST_SUB = 7;  // post-adder computes Z - (X + CIN) when set

    // X operand select
    typedef enum logic [1:0] {
        X_ZERO = 2'b00,
        X_M    = 2'b01,
        X_P    = 2'b10,
        X_DAB  = 2'b11
    } x_sel_t;

    // Z operand select
    typedef enum logic [1:0] {
        Z_ZERO = 2'b00,
        Z_PCIN = 2'b01,
        Z_P    = 2'b10,
        Z_C    = 2'b11
    } z_sel_t;

    // Concatenated X operand for X_DAB: {D[11:0], A1, B1}
    function automatic logic [W_P-1:0] dab_concat(input logic [W_AB-1:0] d,
                                                  input logic [W_AB-1:0] a,
                                                  input logic [W_AB-1:0] b);
        return {d[11:0], a, b};
    endfunction

endpackage

// File: rtl/spartan_dsb48a1_reg_mux.sv
// One pipeline stage: clock-enabled register with asynchronous active-low
// clear, or a plain wire when REG is 0.
module dsp_reg_mux #(
    parameter int WIDTH = 18,
    parameter int REG   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (REG != 0) begin : g_reg
            logic [WIDTH-1:0] q_reg;

            // Stage register: reset clears immediately and overrides CE
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q_reg <= '0;
                end else if (ce) begin
                    q_reg <= d;
                end
            end

            assign q = q_reg;
        end else begin : g_wire
            // Bypassed stage ignores its clock, enable and reset
            logic unused_ctrl;
            assign unused_ctrl = &{1'b0, clk, rst_n, ce};
            assign q = d;
        end
    endgenerate

endmodule

// File: rtl/spartan_dsb48a1.sv
// DSP48A1-style arithmetic slice: 18-bit pre-adder, 18x18 multiplier and a
// 48-bit post-adder/accumulator, each stage optionally registered.
module spartan_dsb48a1
    import spartan_dsp_pkg::*;
#(
    parameter int    A0REG       = 0,
    parameter int    A1REG       = 1,
    parameter int    B0REG       = 0,
    parameter int    B1REG       = 1,
    parameter int    CREG        = 1,
    parameter int    DREG        = 1,
    parameter int    MREG        = 1,
    parameter int    PREG        = 1,
    parameter int    CARRYINREG  = 1,
    parameter int    CARRYOUTREG = 1,
    parameter int    OPMODEREG   = 1,
    parameter string CARRYINSEL  = "OPMODE5",
    parameter string B_INPUT     = "DIRECT"
) (
    input  logic [17:0] A,
    input  logic [17:0] B,
    input  logic [17:0] D,
    input  logic [47:0] C,
    input  logic        CLK,
    input  logic        CARRYIN,
    input  logic [7:0]  OPMODE,
    input  logic [17:0] BCIN,
    input  logic        RSTA,
    input  logic        RSTB,
    input  logic        RSTM,
    input  logic        RSTP,
    input  logic        RSTC,
    input  logic        RSTD,
    input  logic        RSTCARRYIN,
    input  logic        RSTOPMODE,
    input  logic        CEA,
    input  logic        CEB,
    input  logic        CEM,
    input  logic        CEP,
    input  logic        CEC,
    input  logic        CED,
    input  logic        CECARRYIN,
    input  logic        CEOPMODE,
    input  logic [47:0] PCIN,
    output logic [17:0] BCOUT,
    output logic [47:0] PCOUT,
    output logic [47:0] P,
    output logic [35:0] M,
    output logic        CARRYOUT,
    output logic        CARRYOUTF
);

    localparam bit B_FROM_CASCADE = (B_INPUT == "CASCADE");
    localparam bit CIN_FROM_PORT  = (CARRYINSEL == "CARRYIN");

    logic [W_AB-1:0] b_src;
    logic [W_AB-1:0] a0_q;
    logic [W_AB-1:0] a1_q;
    logic [W_AB-1:0] b0_q;
    logic [W_AB-1:0] b1_d;
    logic [W_AB-1:0] b1_q;
    logic [W_AB-1:0] d_q;
    logic [W_P-1:0]  c_q;
    logic [7:0]      op_q;
    logic [W_M-1:0]  m_d;
    logic [W_M-1:0]  m_q;
    logic            cin_d;
    logic            cin_q;
    logic [W_P-1:0]  x_mux;
    logic [W_P-1:0]  z_mux;
    logic [W_P:0]    post_sum;
    logic [W_P-1:0]  p_q;
    logic            cout_q;

    assign b_src = B_FROM_CASCADE ? BCIN : B;

    // ---------------- input stages ----------------
    dsp_reg_mux #(.WIDTH(W_AB), .REG(A0REG)) u_a0 (
        .clk(CLK), .rst_n(RSTA), .ce(CEA), .d(A), .q(a0_q));
    dsp_reg_mux #(.WIDTH(W_AB), .REG(A1REG)) u_a1 (
        .clk(CLK), .rst_n(RSTA), .ce(CEA), .d(a0_q), .q(a1_q));
    dsp_reg_mux #(.WIDTH(W_AB), .REG(B0REG)) u_b0 (
        .clk(CLK), .rst_n(RSTB), .ce(CEB), .d(b_src), .q(b0_q));
    dsp_reg_mux #(.WIDTH(W_AB), .REG(DREG)) u_d (
        .clk(CLK), .rst_n(RSTD), .ce(CED), .d(D), .q(d_q));
    dsp_reg_mux #(.WIDTH(W_P), .REG(CREG)) u_c (
        .clk(CLK), .rst_n(RSTC), .ce(CEC), .d(C), .q(c_q));
    dsp_reg_mux #(.WIDTH(8), .REG(OPMODEREG)) u_op (
        .clk(CLK), .rst_n(RSTOPMODE), .ce(CEOPMODE), .d(OPMODE), .q(op_q));

    // Pre-adder: D +/- B0 when enabled, otherwise B0 passes straight to B1
    always_comb begin
        b1_d = b0_q;
        if (op_q[OP_PRE_EN]) begin
            if (op_q[OP_PRE_SUB]) begin
                b1_d = d_q - b0_q;
            end else begin
                b1_d = d_q + b0_q;
            end
        end
    end

    dsp_reg_mux #(.WIDTH(W_AB), .REG(B1REG)) u_b1 (
        .clk(CLK), .rst_n(RSTB), .ce(CEB), .d(b1_d), .q(b1_q));

    assign BCOUT = b1_q;

    // ---------------- multiplier ----------------
    assign m_d = {{(W_M-W_AB){1'b0}}, b1_q} * {{(W_M-W_AB){1'b0}}, a1_q};

    dsp_reg_mux #(.WIDTH(W_M), .REG(MREG)) u_m (
        .clk(CLK), .rst_n(RSTM), .ce(CEM), .d(m_d), .q(m_q));

    assign M = m_q;

    // ---------------- carry-in ----------------
    assign cin_d = CIN_FROM_PORT ? CARRYIN : op_q[OP_CARRYIN];

    dsp_reg_mux #(.WIDTH(1), .REG(CARRYINREG)) u_cin (
        .clk(CLK), .rst_n(RSTCARRYIN), .ce(CECARRYIN), .d(cin_d), .q(cin_q));

    // X and Z operand selection for the post-adder
    always_comb begin
        x_mux = '0;
        z_mux = '0;
        case (x_sel_t'(op_q[OP_X_LSB +: 2]))
            X_ZERO:  x_mux = '0;
            X_M:     x_mux = {{(W_P-W_M){1'b0}}, m_q};
            X_P:     x_mux = p_q;
            X_DAB:   x_mux = dab_concat(d_q, a1_q, b1_q);
            default: x_mux = '0;
        endcase
        case (z_sel_t'(op_q[OP_Z_LSB +: 2]))
            Z_ZERO:  z_mux = '0;
            Z_PCIN:  z_mux = PCIN;
            Z_P:     z_mux = p_q;
            Z_C:     z_mux = c_q;
            default: z_mux = '0;
        endcase
    end

    // Post-adder at 49 bits so the top bit becomes the carry/borrow out
    always_comb begin
        if (op_q[OP_POST_SUB]) begin
            post_sum = {1'b0, z_mux} - ({1'b0, x_mux} + {{W_P{1'b0}}, cin_q});
        end else begin
            post_sum = {1'b0, z_mux} + {1'b0, x_mux} + {{W_P{1'b0}}, cin_q};
        end
    end

    // ---------------- output stages ----------------
    dsp_reg_mux #(.WIDTH(W_P), .REG(PREG)) u_p (
        .clk(CLK), .rst_n(RSTP), .ce(CEP), .d(post_sum[W_P-1:0]), .q(p_q));
    dsp_reg_mux #(.WIDTH(1), .REG(CARRYOUTREG)) u_cout (
        .clk(CLK), .rst_n(RSTCARRYIN), .ce(CECARRYIN), .d(post_sum[W_P]), .q(cout_q));

    assign P         = p_q;
    assign PCOUT     = p_q;
    assign CARRYOUT  = cout_q;
    assign CARRYOUTF = cout_q;

endmodule

// File: tb/tb_spartan_dsb48a1.sv
// Self-checking bench for spartan_dsb48a1: directed steps followed by a
// randomized run compared against a cycle-history reference model.
module tb_spartan_dsb48a1;

    localparam int NR = 160;

    logic [17:0] a, b, d, bcin;
    logic [47:0] c, pcin;
    logic        clk, carryin;
    logic [7:0]  opmode;
    logic        rsta, rstb, rstm, rstp, rstc, rstd, rstcarryin, rstopmode;
    logic        cea, ceb, cem, cep, cec, ced, cecarryin, ceopmode;

    logic [17:0] bcout, c_bcout;
    logic [47:0] pcout, p, c_pcout, c_p;
    logic [35:0] m, c_m;
    logic        carryout, carryoutf, c_carryout, c_carryoutf;

    int checks = 0;
    int failures = 0;

    spartan_dsb48a1 dut (
        .A(a), .B(b), .D(d), .C(c), .CLK(clk), .CARRYIN(carryin), .OPMODE(opmode),
        .BCIN(bcin), .RSTA(rsta), .RSTB(rstb), .RSTM(rstm), .RSTP(rstp), .RSTC(rstc),
        .RSTD(rstd), .RSTCARRYIN(rstcarryin), .RSTOPMODE(rstopmode), .CEA(cea),
        .CEB(ceb), .CEM(cem), .CEP(cep), .CEC(cec), .CED(ced), .CECARRYIN(cecarryin),
        .CEOPMODE(ceopmode), .PCIN(pcin), .BCOUT(bcout), .PCOUT(pcout), .P(p), .M(m),
        .CARRYOUT(carryout), .CARRYOUTF(carryoutf));

    spartan_dsb48a1 #(.B_INPUT("CASCADE")) dut_casc (
        .A(a), .B(b), .D(d), .C(c), .CLK(clk), .CARRYIN(carryin), .OPMODE(opmode),
        .BCIN(bcin), .RSTA(rsta), .RSTB(rstb), .RSTM(rstm), .RSTP(rstp), .RSTC(rstc),
        .RSTD(rstd), .RSTCARRYIN(rstcarryin), .RSTOPMODE(rstopmode), .CEA(cea),
        .CEB(ceb), .CEM(cem), .CEP(cep), .CEC(cec), .CED(ced), .CECARRYIN(cecarryin),
        .CEOPMODE(ceopmode), .PCIN(pcin), .BCOUT(c_bcout), .PCOUT(c_pcout), .P(c_p),
        .M(c_m), .CARRYOUT(c_carryout), .CARRYOUTF(c_carryoutf));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle just after the last one
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_rst(input logic v);
        rsta = v; rstb = v; rstm = v; rstp = v;
        rstc = v; rstd = v; rstcarryin = v; rstopmode = v;
    endtask

    // Reference: value latched into B1 given pre-adder control, D and B source
    function automatic logic [17:0] pre_ref(input logic [7:0] op, input logic [17:0] dv,
                                            input logic [17:0] bv);
        if (!op[4]) return bv;
        return op[6] ? 18'(dv - bv) : 18'(dv + bv);
    endfunction

    // Reference: post-adder {carry, sum} from the selected operands
    function automatic logic [48:0] post_ref(input logic [7:0] op, input logic [47:0] xm,
                                             input logic [47:0] xp, input logic [47:0] xd,
                                             input logic [47:0] zpcin, input logic [47:0] zc,
                                             input logic ci);
        logic [48:0] xv, zv;
        case (op[1:0])
            2'd0: xv = 49'd0;
            2'd1: xv = {1'b0, xm};
            2'd2: xv = {1'b0, xp};
            default: xv = {1'b0, xd};
        endcase
        case (op[3:2])
            2'd0: zv = 49'd0;
            2'd1: zv = {1'b0, zpcin};
            2'd2: zv = {1'b0, xp};
            default: zv = {1'b0, zc};
        endcase
        return op[7] ? zv - (xv + 49'(ci)) : zv + xv + 49'(ci);
    endfunction

    // Input history (index n+1 holds cycle n; indices 0,1 are the post-reset zeros)
    logic [17:0] ha [0:NR+1];
    logic [17:0] hb [0:NR+1];
    logic [17:0] hd [0:NR+1];
    logic [17:0] hbc[0:NR+1];
    logic [47:0] hc [0:NR+1];
    logic [47:0] hpc[0:NR+1];
    logic [7:0]  hop[0:NR+1];
    logic [17:0] eb [0:NR+1];
    logic [17:0] ebc[0:NR+1];
    logic [35:0] em [0:NR+1];
    logic [47:0] ep [0:NR+1];
    logic        eco[0:NR+1];

    initial begin
        logic [47:0] p0;
        logic [48:0] post;
        logic [47:0] dab;

        // Step 1: all resets asserted with live data
        set_rst(1'b0);
        cea = 1; ceb = 1; cem = 1; cep = 1; cec = 1; ced = 1; cecarryin = 1; ceopmode = 1;
        a = 18'($urandom); b = 18'($urandom); d = 18'($urandom); bcin = 18'($urandom);
        c = {16'($urandom), 32'($urandom)}; pcin = {16'($urandom), 32'($urandom)};
        carryin = 1'b1; opmode = 8'h05;
        cyc(3);
        chk("rst_bcout", 48'(bcout), 48'd0);
        chk("rst_m", 48'(m), 48'd0);
        chk("rst_p", p, 48'd0);
        chk("rst_pcout", pcout, 48'd0);
        chk("rst_carryout", 48'(carryout), 48'd0);
        chk("rst_carryoutf", 48'(carryoutf), 48'd0);
        chk("rst_casc_bcout", 48'(c_bcout), 48'd0);

        // Step 2: plain multiply latency
        set_rst(1'b1);
        a = 18'd10; b = 18'd10; d = 18'd15; c = 48'd0; pcin = 48'd0; opmode = 8'h01;
        cyc(1);
        chk("lat_m_c1", 48'(m), 48'd0);
        cyc(1);
        chk("lat_m_c2", 48'(m), 48'd100);
        chk("lat_p_c2", p, 48'd0);
        cyc(1);
        chk("lat_p_c3", p, 48'd100);

        // Step 3: M + C
        c = 48'd1; opmode = 8'h0D;
        cyc(4);
        chk("madd_p", p, 48'd101);
        chk("madd_co", 48'(carryout), 48'd0);

        // Step 4: pre-subtract then accumulate
        opmode = 8'h59;
        cyc(4);
        chk("pre_bcout", 48'(bcout), 48'd5);
        chk("pre_m", 48'(m), 48'd50);
        p0 = p;
        cyc(1);
        chk("acc_step1", p, p0 + 48'd50);
        cyc(1);
        chk("acc_step2", p, p0 + 48'd100);

        // Step 5: subtract to a negative result, then asynchronous P clear
        c = 48'd0; opmode = 8'h8D;
        cyc(5);
        chk("sub_p", p, 48'hFFFF_FFFF_FF9C);
        chk("sub_pcout", pcout, 48'hFFFF_FFFF_FF9C);
        chk("sub_co", 48'(carryout), 48'd1);
        chk("sub_cof", 48'(carryoutf), 48'd1);
        #2;
        rstp = 1'b0;
        #1;
        chk("rstp_p", p, 48'd0);
        chk("rstp_pcout", pcout, 48'd0);
        cyc(1);
        chk("rstp_m_runs", 48'(m), 48'd100);
        chk("rstp_co_runs", 48'(carryout), 48'd1);
        rstp = 1'b1;

        // Step 6: cascade B input and CEB hold
        bcin = 18'd33;
        cyc(1);
        chk("casc_bcout", 48'(c_bcout), 48'd33);
        ceb = 1'b0; bcin = 18'd77; b = 18'd200;
        cyc(2);
        chk("casc_hold", 48'(c_bcout), 48'd33);
        chk("direct_hold", 48'(bcout), 48'd10);
        ceb = 1'b1;

        // Step 7: randomized run from a clean reset against the history model
        set_rst(1'b0);
        cyc(1);
        for (int i = 0; i < 2; i++) begin
            ha[i] = '0; hb[i] = '0; hd[i] = '0; hbc[i] = '0; hc[i] = '0; hpc[i] = '0;
            hop[i] = '0; eb[i] = '0; ebc[i] = '0; em[i] = '0; ep[i] = '0; eco[i] = 1'b0;
        end
        set_rst(1'b1);
        for (int n = 1; n <= NR; n++) begin
            a = 18'($urandom); b = 18'($urandom); d = 18'($urandom); bcin = 18'($urandom);
            c = {16'($urandom), 32'($urandom)}; pcin = {16'($urandom), 32'($urandom)};
            opmode = 8'($urandom); carryin = 1'($urandom);
            ha[n+1] = a; hb[n+1] = b; hd[n+1] = d; hbc[n+1] = bcin;
            hc[n+1] = c; hpc[n+1] = pcin; hop[n+1] = opmode;
            cyc(1);
            eb[n+1]  = pre_ref(hop[n], hd[n], hb[n+1]);
            ebc[n+1] = pre_ref(hop[n], hd[n], hbc[n+1]);
            em[n+1]  = 36'(36'(eb[n]) * 36'(ha[n]));
            dab = {hd[n][11:0], ha[n], eb[n]};
            post = post_ref(hop[n], 48'(em[n]), ep[n], dab, hpc[n+1], hc[n],
                            (n >= 2) ? hop[n-1][5] : 1'b0);
            ep[n+1]  = post[47:0];
            eco[n+1] = post[48];
            chk($sformatf("rnd%0d_bcout", n), 48'(bcout), 48'(eb[n+1]));
            chk($sformatf("rnd%0d_casc_bcout", n), 48'(c_bcout), 48'(ebc[n+1]));
            chk($sformatf("rnd%0d_m", n), 48'(m), 48'(em[n+1]));
            chk($sformatf("rnd%0d_p", n), p, ep[n+1]);
            chk($sformatf("rnd%0d_pcout", n), pcout, ep[n+1]);
            chk($sformatf("rnd%0d_co", n), 48'(carryout), 48'(eco[n+1]));
            chk($sformatf("rnd%0d_cof", n), 48'(carryoutf), 48'(eco[n+1]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
